// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the decode-stage slice.
// Compile option: REGFILE_BYPASS_EN (see regfile.sv).
package regfile_pkg;

    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;

    typedef logic [31:0]           RegBus;
    typedef logic [RegNumLog2-1:0] RegAddrBus;

    localparam RegBus     ZeroWord   = 32'h0000_0000;
    localparam RegAddrBus NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic RstEnable    = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: priority mux plus optional write-through.
// Compile option: REGFILE_BYPASS_EN enables the same-cycle bypass.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOPRegAddr);
    localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZeroWord);

    logic hit;

`ifdef REGFILE_BYPASS_EN
    // A write landing on the address being read is forwarded this cycle.
    assign hit = (we == WriteEnable) && (waddr != ZERO_ADDR) &&
                 (waddr == raddr) && (re == ReadEnable);
`else
    // Reads always see the stored value; write signals are not observed.
    logic unused_wr;
    assign unused_wr = ^{we, waddr, wdata};
    assign hit = 1'b0;
`endif

    // Highest-priority condition wins; x0 and disabled reads return zero.
    always_comb begin
        rdata = ZERO_DATA;
        if (rst == RstEnable) begin
            rdata = ZERO_DATA;
        end else if (raddr == ZERO_ADDR) begin
            rdata = ZERO_DATA;
        end else if (re == ReadDisable) begin
            rdata = ZERO_DATA;
        end else if (hit) begin
`ifdef REGFILE_BYPASS_EN
            rdata = wdata;
`else
            rdata = stored;
`endif
        end else begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32-entry GPR file: two combinational reads, one synchronous write, x0 = 0.
// Compile option: REGFILE_BYPASS_EN forwards same-cycle writes to the reads.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = $bits(RegBus),
    parameter int ADDR_W   = RegNumLog2,
    parameter int NUM_REGS = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOPRegAddr);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = (we == WriteEnable) && (waddr != ZERO_ADDR);

    // Storage: cleared asynchronously; x0 is never written so stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .rst    (rst),
        .re     (re1),
        .raddr  (raddr1),
        .stored (regs[raddr1]),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata1)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .rst    (rst),
        .re     (re2),
        .raddr  (raddr2),
        .stored (regs[raddr2]),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: vector table, scoreboard queue,
// plus hand-written bypass and async-reset sequences.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    always #5 clk = ~clk;

    regfile #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_REGS (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t        vt[11];
    logic [31:0] mdl[32];

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0011;
`endif

    task automatic push(input string n, input logic [31:0] a,
                        input logic [31:0] b);
        exp_t e;
        e.name = n;
        e.e1   = a;
        e.e2   = b;
        sbq.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sbq.pop_front();
        if (rdata1 !== e.e1 || rdata2 !== e.e2) begin
            failures++;
            $display("FAIL %s: rdata1=%h rdata2=%h required %h %h",
                     e.name, rdata1, rdata2, e.e1, e.e2);
        end
    endtask

    task automatic set_rd(input logic r1, input logic [4:0] a1,
                          input logic r2, input logic [4:0] a2);
        re1    = r1;
        raddr1 = a1;
        re2    = r2;
        raddr2 = a2;
    endtask

    task automatic sweep(input string n);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            set_rd(1'b1, 5'(i), 1'b1, 5'(31 - i));
            push(n, mdl[i], mdl[31 - i]);
            #1 compare();
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 5'd3,  32'h1234_5678, 1'b1, 5'd4,  1'b1, 5'd0,
                   32'h0, 32'h0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd3,
                   32'h1234_5678, 32'h0};
        vt[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  1'b1, 5'd3,
                   32'h0, 32'h1234_5678};
        vt[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd3,  1'b1, 5'd0,
                   32'h1234_5678, 32'h0};
        vt[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 5'd0,
                   32'h0, 32'h0};
        vt[5]  = '{1'b1, 5'd10, 32'h0000_000A, 1'b1, 5'd3,  1'b1, 5'd3,
                   32'h1234_5678, 32'h1234_5678};
        vt[6]  = '{1'b1, 5'd20, 32'h0000_0014, 1'b1, 5'd10, 1'b1, 5'd0,
                   32'hA, 32'h0};
        vt[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 1'b1, 5'd20,
                   32'hA, 32'h14};
        vt[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd20, 1'b1, 5'd10,
                   32'h14, 32'hA};
        vt[9]  = '{1'b1, 5'd7,  32'h0000_0011, 1'b1, 5'd10, 1'b1, 5'd3,
                   32'hA, 32'h1234_5678};
        vt[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd7,
                   32'h11, 32'h11};

        for (int i = 0; i < 32; i++) mdl[i] = '0;

        // Reset held, with a write attempt that must be lost.
        rst   = 1'b0;
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'hCAFE_F00D;
        set_rd(1'b1, 5'd5, 1'b1, 5'd31);
        repeat (2) @(negedge clk);
        push("reset_hold", 32'h0, 32'h0);
        #1 compare();

        @(negedge clk);
        rst = 1'b1;
        we  = 1'b0;
        sweep("reset_sweep");

        // Table-driven vectors; outputs checked before the write edge.
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            we    = vt[v].we;
            waddr = vt[v].waddr;
            wdata = vt[v].wdata;
            set_rd(vt[v].re1, vt[v].raddr1, vt[v].re2, vt[v].raddr2);
            push($sformatf("vec%0d", v), vt[v].e1, vt[v].e2);
            #1 compare();
            if (vt[v].we && vt[v].waddr != 5'd0)
                mdl[vt[v].waddr] = vt[v].wdata;
        end
        @(negedge clk);
        we = 1'b0;
        sweep("after_table");

        // Same-cycle write and read of r7 on both ports.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'hDEAD_BEEF;
        set_rd(1'b1, 5'd7, 1'b1, 5'd7);
        push("bypass_same_cycle", BYP_EXP, BYP_EXP);
        #1 compare();
        @(negedge clk);
        we = 1'b0;
        push("bypass_next_cycle", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        #1 compare();

        // Fill r1..r31 with their index, then reset between edges.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we    = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i);
        end
        @(negedge clk);
        we = 1'b0;
        set_rd(1'b1, 5'd5, 1'b1, 5'd31);
        push("filled", 32'd5, 32'd31);
        #1 compare();
        #2 rst = 1'b0;
        push("async_reset_now", 32'h0, 32'h0);
        #1 compare();
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'h9999_9999;
        @(posedge clk);
        @(negedge clk);
        set_rd(1'b1, 5'd9, 1'b1, 5'd9);
        push("write_during_reset", 32'h0, 32'h0);
        #1 compare();
        rst = 1'b1;
        we  = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        sweep("post_reset_sweep");

        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0",
                     sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
